dvp_capture: RTL and testbench

- Camera-side pixel capture stage that runs downstream of the SCCB configuration sequencer.
- Once configuration completes (enable high), it samples the OV7670 DVP bus (cam_pclk, cam_vsync, cam_href, cam_data) in the PCLK domain.
- Pairs bytes into RGB565 pixels and buffers them in a small FIFO.
- Presents pixels on a valid/ready stream with start-of-frame and end-of-line markers, plus measured frame geometry and sticky error status.

---
 rtl/dvp_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_dvp_capture.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture.sv
// OV7670 DVP capture: synchronises the camera bus into PCLK, pairs bytes into RGB565,
// buffers pixels in a small FIFO and presents them as a valid/ready stream with frame status.
module dvp_capture #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 10
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             enable,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    output logic [15:0]      pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [CNT_W-1:0] line_pixels,
    output logic [CNT_W-1:0] frame_lines,
    output logic             overflow,
    output logic             odd_byte,
    input  logic             clear_status,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic       pclk_s1, pclk_s2, pclk_s3;
    logic       vsync_s1, vsync_s2, vsync_s3;
    logic       href_s1, href_s2, href_s3;
    logic [7:0] data_s1, data_s2;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the synchroniser.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pclk_s1  <= 1'b0;
            pclk_s2  <= 1'b0;
            pclk_s3  <= 1'b0;
            vsync_s1 <= 1'b0;
            vsync_s2 <= 1'b0;
            vsync_s3 <= 1'b0;
            href_s1  <= 1'b0;
            href_s2  <= 1'b0;
            href_s3  <= 1'b0;
            data_s1  <= 8'h00;
            data_s2  <= 8'h00;
        end else begin
            pclk_s1  <= cam_pclk;
            pclk_s2  <= pclk_s1;
            pclk_s3  <= pclk_s2;
            vsync_s1 <= cam_vsync;
            vsync_s2 <= vsync_s1;
            vsync_s3 <= vsync_s2;
            href_s1  <= cam_href;
            href_s2  <= href_s1;
            href_s3  <= href_s2;
            data_s1  <= cam_data;
            data_s2  <= data_s1;
        end
    end

    logic sample_evt, vsync_fall, vsync_rise, href_fall;
    assign sample_evt = pclk_s2 && !pclk_s3;
    assign vsync_fall = !vsync_s2 && vsync_s3;
    assign vsync_rise = vsync_s2 && !vsync_s3;
    assign href_fall  = !href_s2 && href_s3;

    logic [1:0]       state;
    logic             byte_sel;
    logic             sof_pending;
    logic             mark_ok;
    logic [7:0]       hold_byte;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;

    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, last_ptr;
    logic [AW:0]   count;
    logic [15:0]   last_data;

    logic active, href_hi_evt, push_req, push_ok, drop, pop, empty, full, line_end, mark;

    assign active      = (state == ST_ACTIVE);
    assign href_hi_evt = active && sample_evt && href_s2;
    assign push_req    = href_hi_evt && byte_sel;
    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign pop         = !empty && pix_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign line_end    = active && href_fall;
    assign mark        = line_end && mark_ok;
    assign last_ptr    = wr_ptr - AW'(1);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            byte_sel    <= 1'b0;
            sof_pending <= 1'b0;
            hold_byte   <= 8'h00;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_pixels <= '0;
            frame_lines <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable)
                        state <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (vsync_fall) begin
                        state       <= ST_ACTIVE;
                        pix_cnt     <= '0;
                        line_cnt    <= '0;
                        sof_pending <= 1'b1;
                        byte_sel    <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (href_hi_evt) begin
                        if (!byte_sel) begin
                            hold_byte <= data_s2;
                            byte_sel  <= 1'b1;
                        end else begin
                            byte_sel    <= 1'b0;
                            sof_pending <= 1'b0;
                            if (pix_cnt != '1)
                                pix_cnt <= pix_cnt + CNT_W'(1);
                        end
                    end else if (href_fall) begin
                        // An unpaired trailing byte is simply dropped here.
                        line_pixels <= pix_cnt;
                        pix_cnt     <= '0;
                        byte_sel    <= 1'b0;
                        if (pix_cnt != '0)
                            line_cnt <= line_cnt + CNT_W'(1);
                    end
                    if (vsync_rise) begin
                        frame_lines <= line_cnt;
                        state       <= enable ? ST_SYNC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= 16'h0000;
            mark_ok   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_data <= mem[rd_ptr][17:2];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            // mark_ok tracks whether the newest pixel of this frame is still in the FIFO.
            if (!active)
                mark_ok <= 1'b0;
            else if (push_ok)
                mark_ok <= 1'b1;
            else if (drop)
                mark_ok <= 1'b0;
            else if (pop && count == ONE_CNT)
                mark_ok <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; emptiness is carried entirely by the pointers
    // and count, so stale contents are never observable.
    always_ff @(posedge PCLK) begin
        if (push_ok)
            mem[wr_ptr] <= {hold_byte, data_s2, sof_pending, 1'b0};
        if (mark)
            mem[last_ptr][0] <= 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            overflow <= 1'b0;
            odd_byte <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (clear_status)
                overflow <= 1'b0;
            if (line_end && byte_sel)
                odd_byte <= 1'b1;
            else if (clear_status)
                odd_byte <= 1'b0;
        end
    end

    assign pix_valid = !empty;
    assign pix_data  = empty ? last_data : mem[rd_ptr][17:2];
    assign pix_sof   = !empty && mem[rd_ptr][1];
    assign pix_eol   = !empty && mem[rd_ptr][0];
    assign busy      = active;

endmodule

// File: tb/tb_dvp_capture.sv
// Self-checking bench for dvp_capture: directed frames plus randomised traffic checked
// against a byte-pair stream model with a bounded-latency scoreboard.
module tb_dvp_capture;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 10;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic             enable;
    logic             cam_pclk;
    logic             cam_vsync;
    logic             cam_href;
    logic [7:0]       cam_data;
    logic [15:0]      pix_data;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_valid;
    logic             pix_ready;
    logic [CNT_W-1:0] line_pixels;
    logic [CNT_W-1:0] frame_lines;
    logic             overflow;
    logic             odd_byte;
    logic             clear_status;
    logic             busy;

    always #5 PCLK = ~PCLK;

    dvp_capture #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .enable(enable),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .line_pixels(line_pixels), .frame_lines(frame_lines),
        .overflow(overflow), .odd_byte(odd_byte), .clear_status(clear_status), .busy(busy)
    );

    // eol_mode: 0 = must be clear, 1 = must be set, 2 = may be lost if popped before line end
    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic [1:0]  eol_mode;
    } beat_t;

    beat_t      exp_q[$];
    logic [15:0] got_q[$];
    logic        got_sof_q[$];
    logic [7:0]  line_b[$];

    int n_vec = 0;
    int n_err = 0;
    int ready_mode = 1;   // 0 = hold low, 1 = always high, 2 = random with bounded stall
    bit cap_frame = 1'b0;
    bit first_pix = 1'b0;
    bit exp_ovf = 1'b0;
    bit exp_odd = 1'b0;
    int exp_lines = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #2;
    endtask

    initial begin : ready_drv
        int stall;
        stall = 0;
        pix_ready = 1'b0;
        forever begin
            @(posedge PCLK);
            #2;
            case (ready_mode)
                0: pix_ready = 1'b0;
                1: pix_ready = 1'b1;
                default: begin
                    if (stall >= 3 || $urandom_range(0, 3) != 0) begin
                        pix_ready = 1'b1;
                        stall = 0;
                    end else begin
                        pix_ready = 1'b0;
                        stall++;
                    end
                end
            endcase
        end
    end

    initial begin : compare
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_sof, prev_eol;
        beat_t       e;
        prev_stall = 1'b0;
        prev_data  = 16'h0;
        prev_sof   = 1'b0;
        prev_eol   = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(pix_valid), 32'd1);
                    check("hold_data", 32'(pix_data), 32'(prev_data));
                    check("hold_sof", 32'(pix_sof), 32'(prev_sof));
                    if (prev_eol)
                        check("hold_eol", 32'(pix_eol), 32'd1);
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(pix_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(pix_data), 32'(e.data));
                        check("beat_sof", 32'(pix_sof), 32'(e.sof));
                        if (e.eol_mode != 2'd2)
                            check("beat_eol", 32'(pix_eol), 32'(e.eol_mode[0]));
                    end
                    got_q.push_back(pix_data);
                    got_sof_q.push_back(pix_sof);
                end
                prev_stall = pix_valid && !pix_ready;
                prev_data  = pix_data;
                prev_sof   = pix_sof;
                prev_eol   = pix_eol;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic fill_seq(input logic [7:0] start, input int n);
        line_b.delete();
        for (int i = 0; i < n; i++)
            line_b.push_back(start + 8'(i));
    endtask

    task automatic fill_rand(input int n);
        line_b.delete();
        for (int i = 0; i < n; i++)
            line_b.push_back(8'($urandom));
    endtask

    task automatic frame_start();
        cam_pclk  = 1'b0;
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        tick(6);
        cap_frame = enable;
        first_pix = 1'b1;
        exp_lines = 0;
        cam_vsync = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        tick(8);
        if (cap_frame)
            check("frame_lines", 32'(frame_lines), 32'(exp_lines));
        check("overflow_flag", 32'(overflow), 32'(exp_ovf));
        check("odd_byte_flag", 32'(odd_byte), 32'(exp_odd));
    endtask

    // Drives the bytes in line_b; the expected pixel stream is derived by pairing them.
    task automatic send_line(input bit finish_line);
        int    np;
        beat_t e;
        np = line_b.size() / 2;
        if (cap_frame) begin
            for (int i = 0; i < np; i++) begin
                e.data = {line_b[2*i], line_b[2*i+1]};
                e.sof  = first_pix;
                first_pix = 1'b0;
                if (finish_line && i == np - 1)
                    e.eol_mode = (ready_mode == 0) ? 2'd1 : 2'd2;
                else
                    e.eol_mode = 2'd0;
                if (ready_mode == 0 && exp_q.size() >= FIFO_DEPTH)
                    exp_ovf = 1'b1;
                else
                    exp_q.push_back(e);
            end
            if (finish_line) begin
                if (line_b.size() % 2 != 0)
                    exp_odd = 1'b1;
                if (np > 0)
                    exp_lines++;
            end
        end
        foreach (line_b[i]) begin
            cam_pclk = 1'b0;
            cam_href = 1'b1;
            cam_data = line_b[i];
            tick(2);
            cam_pclk = 1'b1;
            tick(2);
        end
        if (finish_line) begin
            cam_pclk = 1'b0;
            cam_href = 1'b0;
            cam_data = 8'h00;
            tick(10);
            if (cap_frame)
                check("line_pixels", 32'(line_pixels), 32'(np));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++)
            tick(1);
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_pulse();
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        exp_ovf = 1'b0;
        exp_odd = 1'b0;
        tick(1);
        check("clear_overflow", 32'(overflow), 32'd0);
        check("clear_odd_byte", 32'(odd_byte), 32'd0);
    endtask

    initial begin : main
        PRESET       = 1'b1;
        enable       = 1'b0;
        cam_pclk     = 1'b0;
        cam_vsync    = 1'b1;
        cam_href     = 1'b0;
        cam_data     = 8'h00;
        clear_status = 1'b0;
        ready_mode   = 1;
        tick(3);
        PRESET = 1'b0;
        tick(1);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_sof", 32'(pix_sof), 32'd0);
        check("rst_eol", 32'(pix_eol), 32'd0);
        check("rst_line_pixels", 32'(line_pixels), 32'd0);
        check("rst_frame_lines", 32'(frame_lines), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_odd_byte", 32'(odd_byte), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        tick(4);

        // Two lines of four pixels, consumer always ready.
        got_q.delete();
        got_sof_q.delete();
        frame_start();
        check("busy_active", 32'(busy), 32'd1);
        fill_seq(8'h01, 8);
        send_line(1'b1);
        fill_seq(8'h09, 8);
        send_line(1'b1);
        frame_end();
        wait_drain();
        check("t1_beats", 32'(got_q.size()), 32'd8);
        if (got_q.size() == 8) begin
            check("t1_first", 32'(got_q[0]), 32'h0102);
            check("t1_fourth", 32'(got_q[3]), 32'h0708);
            check("t1_last", 32'(got_q[7]), 32'h0F10);
            check("t1_sof_first", 32'(got_sof_q[0]), 32'd1);
            check("t1_sof_fifth", 32'(got_sof_q[4]), 32'd0);
        end
        check("t1_line_pixels", 32'(line_pixels), 32'd4);
        check("t1_frame_lines", 32'(frame_lines), 32'd2);

        // Same frame with the consumer stalled: FIFO fills, the rest is dropped.
        ready_mode = 0;
        tick(2);
        got_q.delete();
        frame_start();
        fill_seq(8'h01, 8);
        send_line(1'b1);
        fill_seq(8'h09, 8);
        send_line(1'b1);
        frame_end();
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_valid", 32'(pix_valid), 32'd1);
        ready_mode = 1;
        wait_drain();
        check("t2_beats", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("t2_first", 32'(got_q[0]), 32'h0102);
            check("t2_last", 32'(got_q[3]), 32'h0708);
        end
        clear_pulse();

        // Odd-length line followed by a normal one.
        got_q.delete();
        frame_start();
        fill_seq(8'h21, 7);
        send_line(1'b1);
        check("t3_odd_byte", 32'(odd_byte), 32'd1);
        check("t3_line_pixels", 32'(line_pixels), 32'd3);
        fill_seq(8'hA1, 4);
        send_line(1'b1);
        frame_end();
        wait_drain();
        check("t3_beats", 32'(got_q.size()), 32'd5);
        if (got_q.size() == 5) begin
            check("t3_third", 32'(got_q[2]), 32'h2526);
            check("t3_fourth", 32'(got_q[3]), 32'hA1A2);
            check("t3_fifth", 32'(got_q[4]), 32'hA3A4);
        end
        clear_pulse();

        // Enable dropped mid-frame: that frame completes, the next is ignored.
        got_q.delete();
        frame_start();
        fill_rand(8);
        send_line(1'b1);
        enable = 1'b0;
        fill_rand(8);
        send_line(1'b1);
        frame_end();
        check("t4_busy_after", 32'(busy), 32'd0);
        frame_start();
        fill_rand(8);
        send_line(1'b1);
        frame_end();
        check("t4_busy_idle", 32'(busy), 32'd0);
        wait_drain();
        check("t4_beats", 32'(got_q.size()), 32'd8);
        enable = 1'b1;
        tick(4);

        // Reset mid-line with two pixels buffered.
        ready_mode = 0;
        tick(2);
        frame_start();
        fill_seq(8'h41, 4);
        send_line(1'b0);
        tick(6);
        check("t5_buffered", 32'(pix_valid), 32'd1);
        PRESET = 1'b1;
        tick(1);
        PRESET = 1'b0;
        exp_q.delete();
        cap_frame = 1'b0;
        exp_ovf   = 1'b0;
        exp_odd   = 1'b0;
        check("t5_valid_after_rst", 32'(pix_valid), 32'd0);
        check("t5_busy_after_rst", 32'(busy), 32'd0);
        check("t5_line_pixels_rst", 32'(line_pixels), 32'd0);
        check("t5_frame_lines_rst", 32'(frame_lines), 32'd0);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        tick(6);
        frame_end();
        ready_mode = 1;
        got_q.delete();
        got_sof_q.delete();
        frame_start();
        fill_seq(8'h51, 4);
        send_line(1'b1);
        frame_end();
        wait_drain();
        check("t5_beats", 32'(got_q.size()), 32'd2);
        if (got_sof_q.size() > 0) begin
            check("t5_first_sof", 32'(got_sof_q[0]), 32'd1);
            check("t5_first_data", 32'(got_q[0]), 32'h5152);
        end

        // Random traffic with random backpressure.
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            frame_start();
            for (int l = 0; l < 3; l++) begin
                fill_rand($urandom_range(2, 16));
                send_line(1'b1);
            end
            frame_end();
        end
        ready_mode = 1;
        wait_drain();
        check("t6_no_overflow", 32'(overflow), 32'd0);

        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
